// File: rtl/bit_pos_scanner_pkg.sv
// bit_pos_scanner_pkg
//   Shared types and helpers for the bit position scanner.
//   state_e            : scanner FSM states.
//   lowest_set_idx     : index of the lowest set bit (0 for an all-zero mask),
//                        the inverse of building a mask with 1 << idx.
//   lowest_set_onehot  : one-hot vector of the lowest set bit (0 for zero).
//   Helpers operate on MaxWidth-bit vectors; callers zero-extend narrower masks.
package bit_pos_scanner_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  localparam int unsigned MaxWidth = 256;

  function automatic int unsigned lowest_set_idx(input logic [MaxWidth-1:0] mask);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (!found && mask[i]) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [MaxWidth-1:0] lowest_set_onehot(input logic [MaxWidth-1:0] mask);
    return mask & (~mask + MaxWidth'(1));
  endfunction

endpackage

// File: rtl/bit_pos_scanner_lzc.sv
// lzc
//   Leading/trailing zero counter (common_cells compatible interface).
//   Parameters:
//     WIDTH     : input width.
//     MODE      : 0 = count trailing zeros, 1 = count leading zeros.
//     CNT_WIDTH : width of the count output.
//   Ports:
//     in_i    : vector to scan.
//     cnt_o   : number of zeros before the first set bit in scan order
//               (0 when the input is empty).
//     empty_o : input is all zeros.
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // Leading mode scans a bit-reversed copy so one trailing-order loop serves both.
  logic [WIDTH-1:0] scan;

  for (genvar g = 0; g < WIDTH; g++) begin : g_order
    assign scan[g] = MODE ? in_i[WIDTH-1-g] : in_i[g];
  end

  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (empty_o && scan[i]) begin
        cnt_o   = CNT_WIDTH'(i);
        empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bit_pos_scanner.sv
// bit_pos_scanner
//   Accepts a WIDTH-bit mask and emits the index of every set bit, lowest
//   first, one per output handshake. An all-zero mask yields a single beat
//   flagged zero_o. No new mask is accepted until the scan completes.
//   Ports:
//     clk_i, rst_ni  : clock, asynchronous active-low reset.
//     mask_i         : mask to scan.
//     mask_valid_i   : mask_i is valid.
//     mask_ready_o   : block accepts a mask (IDLE only).
//     idx_o          : index of the lowest remaining set bit.
//     onehot_o       : one-hot form of idx_o (zero on a zero beat).
//     last_o         : final beat for this mask.
//     zero_o         : the accepted mask was all zeros.
//     idx_valid_o    : output beat valid.
//     idx_ready_i    : consumer takes the beat.
module bit_pos_scanner
  import bit_pos_scanner_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IdxWidth = $clog2(WIDTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [WIDTH-1:0]    mask_i,
  input  logic                mask_valid_i,
  output logic                mask_ready_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic [WIDTH-1:0]    onehot_o,
  output logic                last_o,
  output logic                zero_o,
  output logic                idx_valid_o,
  input  logic                idx_ready_i
);

  state_e               state;
  state_e               next_state;
  logic [WIDTH-1:0]     remaining;
  logic [IdxWidth-1:0]  lzc_cnt;
  logic                 lzc_empty;
  logic [MaxWidth-1:0]  oh_full;
  logic [WIDTH-1:0]     onehot_rem;
  logic                 handshake;

  lzc #(
    .WIDTH     (WIDTH),
    .MODE      (1'b0),
    .CNT_WIDTH (IdxWidth)
  ) u_tz (
    .in_i    (remaining),
    .cnt_o   (lzc_cnt),
    .empty_o (lzc_empty)
  );

  assign oh_full    = lowest_set_onehot(MaxWidth'(remaining));
  assign onehot_rem = oh_full[WIDTH-1:0];
  assign handshake  = idx_valid_o && idx_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      remaining <= '0;
    end else if (state == IDLE && mask_valid_i) begin
      remaining <= mask_i;
    end else if (handshake) begin
      remaining <= remaining & ~onehot_rem;
    end
  end

  // Outputs derive from state and the remaining register only, so backpressure
  // holds them stable and idx_ready_i never reaches idx_valid_o.
  always_comb begin
    next_state   = state;
    mask_ready_o = 1'b0;
    idx_valid_o  = 1'b0;
    idx_o        = '0;
    onehot_o     = '0;
    last_o       = 1'b0;
    zero_o       = 1'b0;
    unique case (state)
      IDLE: begin
        mask_ready_o = 1'b1;
        if (mask_valid_i) begin
          next_state = EMIT;
        end
      end
      EMIT: begin
        idx_valid_o = 1'b1;
        idx_o       = lzc_empty ? '0 : lzc_cnt;
        onehot_o    = onehot_rem;
        zero_o      = lzc_empty;
        last_o      = lzc_empty || ((remaining & ~onehot_rem) == '0);
        if (idx_ready_i && last_o) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Cross-checks between the lzc instance and the package helpers.
  a_zero_detect : assert property (@(posedge clk_i) disable iff (!rst_ni)
    lzc_empty == (remaining == '0));
  a_idx_match : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !lzc_empty |-> (lowest_set_idx(MaxWidth'(remaining)) == 32'(lzc_cnt)));
  a_onehot_fits : assert property (@(posedge clk_i) disable iff (!rst_ni)
    oh_full == MaxWidth'(onehot_rem));

endmodule

// File: tb/tb_bit_pos_scanner.sv
// tb_bit_pos_scanner
//   Scoreboard bench: the driver pushes the expected beats of each accepted
//   mask into a queue; an independent monitor pops and compares on every
//   output handshake, and checks stability under backpressure.
module tb_bit_pos_scanner;

  localparam int unsigned W  = 32;
  localparam int unsigned IW = 5;

  typedef struct {
    int unsigned   idx;
    logic [W-1:0]  onehot;
    logic          last;
    logic          zero;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  mask;
  logic          mask_valid;
  logic          mask_ready;
  logic [IW-1:0] idx;
  logic [W-1:0]  onehot;
  logic          last;
  logic          zero;
  logic          idx_valid;
  logic          idx_ready;

  int unsigned vectors   = 0;
  int unsigned miscompares = 0;
  int unsigned ready_mode = 0;  // 0: ready held 1, 1: random, 2: manual
  beat_t       sb[$];

  bit_pos_scanner #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mask_i       (mask),
    .mask_valid_i (mask_valid),
    .mask_ready_o (mask_ready),
    .idx_o        (idx),
    .onehot_o     (onehot),
    .last_o       (last),
    .zero_o       (zero),
    .idx_valid_o  (idx_valid),
    .idx_ready_i  (idx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Reference: one beat per set bit, lowest first; a zero mask is one zero beat.
  task automatic push_expected(input logic [W-1:0] m);
    beat_t b;
    if (m == '0) begin
      b.idx = 0; b.onehot = '0; b.last = 1'b1; b.zero = 1'b1;
      sb.push_back(b);
    end else begin
      for (int unsigned i = 0; i < W; i++) begin
        if (m[i]) begin
          b.idx    = i;
          b.onehot = W'(1) << i;
          b.last   = ((m >> i) >> 1) == '0;
          b.zero   = 1'b0;
          sb.push_back(b);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) idx_ready = 1'b1;
    else if (ready_mode == 1) idx_ready = 1'($urandom_range(0, 1));
  end

  // Monitor
  initial begin
    logic          stalled;
    logic [IW-1:0] h_idx;
    logic [W-1:0]  h_oh;
    logic          h_last, h_zero;
    beat_t         e;
    stalled = 1'b0;
    h_idx = '0; h_oh = '0; h_last = 1'b0; h_zero = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", 64'(idx_valid), 64'd1);
          check("stall_hold", {idx, onehot, last, zero}, {h_idx, h_oh, h_last, h_zero});
        end
        stalled = 1'b0;
        if (idx_valid && idx_ready) begin
          if (sb.size() == 0) begin
            check("extra_beat", 64'(idx), 64'hdead);
          end else begin
            e = sb.pop_front();
            check("beat_idx", 64'(idx), 64'(e.idx));
            check("beat_onehot", 64'(onehot), 64'(e.onehot));
            check("beat_last_zero", {last, zero}, {e.last, e.zero});
          end
        end else if (idx_valid) begin
          stalled = 1'b1;
          h_idx = idx; h_oh = onehot; h_last = last; h_zero = zero;
        end
      end
    end
  end

  task automatic send_mask(input logic [W-1:0] m);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    @(posedge clk); #1;
    mask = m;
    mask_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = mask_ready;
      if (acc) push_expected(m);
      @(posedge clk); #1;
      n++;
    end
    mask_valid = 1'b0;
    mask = $urandom;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  // Wait for the scoreboard to drain, then mask_ready must be up the next cycle.
  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
    check("ready_after_last", {mask_ready, idx_valid}, 2'b10);
  endtask

  initial begin
    logic [W-1:0] m;
    rst_n = 1'b0; mask = '0; mask_valid = 1'b0; idx_ready = 1'b1;
    #12;
    check("reset_outputs", {mask_ready, idx_valid, idx, onehot, last, zero},
          {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0});
    @(negedge clk); rst_n = 1'b1;

    ready_mode = 0;
    send_mask(32'h0000aaee); drain();
    send_mask(32'h00000020); drain();
    send_mask(32'h00000000); drain();

    ready_mode = 2; idx_ready = 1'b0;
    send_mask(32'h80000001);
    repeat (3) @(posedge clk);
    #1 idx_ready = 1'b1;
    drain();

    ready_mode = 1;
    send_mask(32'hffffffff); drain();

    ready_mode = 0;
    send_mask(32'h0000f000);
    @(negedge clk);
    @(posedge clk); #1;
    sb.delete();
    rst_n = 1'b0;
    #2;
    check("midscan_reset", {mask_ready, idx_valid, idx, onehot, last, zero},
          {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    send_mask(32'h00000004); drain();

    ready_mode = 1;
    for (int k = 0; k < 20; k++) begin
      m = $urandom;
      if (k % 4 == 1) m = m & $urandom & $urandom;
      if (k % 7 == 3) m = '0;
      send_mask(m); drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
